// File: rtl/instr_decode_stage.sv
// RISC-V instruction decode stage: combinational field/immediate decode
// feeding a small FIFO of decoded entries with valid/ready on both sides.
package instr_decode_pkg;
    typedef enum logic [2:0] {
        INSTR_TYPE_R = 3'd0,
        INSTR_TYPE_I = 3'd1,
        INSTR_TYPE_S = 3'd2,
        INSTR_TYPE_B = 3'd3,
        INSTR_TYPE_U = 3'd4,
        INSTR_TYPE_J = 3'd5
    } instr_type_enum;
endpackage

module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic [2:0]                 funct3,
    output logic [6:0]                 funct7,
    output logic [XLEN-1:0]            imm,
    output instr_type_enum             instr_type,
    output logic                       illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam bit RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        instr_type_enum  itype;
        logic            illegal;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;
    logic [6:0]      op;
    logic            is_r, is_i, is_s, is_b, is_u, is_j;

    assign op = in_instr[6:0];

    always_comb begin
        is_r = (op == 7'b0110011) || (RV64 && op == 7'b0111011);
        is_i = (op == 7'b0010011) || (op == 7'b0000011) ||
               (op == 7'b1100111) || (op == 7'b1110011) ||
               (op == 7'b0001111) || (RV64 && op == 7'b0011011);
        is_s = (op == 7'b0100011);
        is_b = (op == 7'b1100011);
        is_u = (op == 7'b0110111) || (op == 7'b0010111);
        is_j = (op == 7'b1101111);
    end

    // Raw register/funct fields pass through even for illegal encodings.
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.itype   = INSTR_TYPE_R;
        dec.illegal = 1'b1;
        dec.imm     = '0;
        unique case (1'b1)
            is_r: begin
                dec.illegal = 1'b0;
            end
            is_i: begin
                dec.itype   = INSTR_TYPE_I;
                dec.illegal = 1'b0;
                dec.imm     = XLEN'($signed(in_instr[31:20]));
            end
            is_s: begin
                dec.itype   = INSTR_TYPE_S;
                dec.illegal = 1'b0;
                dec.imm     = XLEN'($signed({in_instr[31:25],
                                             in_instr[11:7]}));
            end
            is_b: begin
                dec.itype   = INSTR_TYPE_B;
                dec.illegal = 1'b0;
                dec.imm     = XLEN'($signed({in_instr[31], in_instr[7],
                                             in_instr[30:25],
                                             in_instr[11:8], 1'b0}));
            end
            is_u: begin
                dec.itype   = INSTR_TYPE_U;
                dec.illegal = 1'b0;
                dec.imm     = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            is_j: begin
                dec.itype   = INSTR_TYPE_J;
                dec.illegal = 1'b0;
                dec.imm     = XLEN'($signed({in_instr[31],
                                             in_instr[19:12],
                                             in_instr[20],
                                             in_instr[30:21], 1'b0}));
            end
            default: begin
            end
        endcase
    end

    assign in_ready  = (count_q < CW'(DEPTH)) && !rst;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !push)
                count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Empty queue presents an all-zero head (type R, not illegal).
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_pc     = head.pc;
    assign rd         = head.rd;
    assign rs1        = head.rs1;
    assign rs2        = head.rs2;
    assign funct3     = head.funct3;
    assign funct7     = head.funct7;
    assign imm        = head.imm;
    assign instr_type = head.itype;
    assign illegal    = head.illegal;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode table on RV32 and RV64
// instances, then backpressure, streaming, flush and reset sequences.
module tb_instr_decode_stage;
    import instr_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, ready64;
    logic [31:0] in_instr;
    logic [63:0] pc64;

    logic        in_ready, out_valid, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  count;
    instr_type_enum instr_type;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] out_pc64, imm64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  funct3_64;
    logic [6:0]  funct7_64;
    logic [2:0]  count64;
    instr_type_enum instr_type64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(pc64[31:0]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .instr_type(instr_type), .illegal(illegal), .count(count)
    );

    instr_decode_stage #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(pc64),
        .out_valid(out_valid64), .out_ready(ready64),
        .out_pc(out_pc64), .rd(rd64), .rs1(rs1_64), .rs2(rs2_64),
        .funct3(funct3_64), .funct7(funct7_64), .imm(imm64),
        .instr_type(instr_type64), .illegal(illegal64),
        .count(count64)
    );

    typedef struct {
        logic [31:0]    instr;
        logic [63:0]    pc;
        instr_type_enum t32;
        logic           ill32;
        instr_type_enum t64;
        logic           ill64;
        logic [63:0]    imm;
        logic [4:0]     rd;
        logic [4:0]     rs1;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'h100, INSTR_TYPE_I, 1'b0,
                     INSTR_TYPE_I, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 5'd0};
        vecs[1]  = '{32'hFE000EE3, 64'h104, INSTR_TYPE_B, 1'b0,
                     INSTR_TYPE_B, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 5'd0};
        vecs[2]  = '{32'h0080006F, 64'h108, INSTR_TYPE_J, 1'b0,
                     INSTR_TYPE_J, 1'b0, 64'h8, 5'd0, 5'd0};
        vecs[3]  = '{32'h123450B7, 64'h10C, INSTR_TYPE_U, 1'b0,
                     INSTR_TYPE_U, 1'b0, 64'h1234_5000, 5'd1, 5'd8};
        vecs[4]  = '{32'hFE112E23, 64'h110, INSTR_TYPE_S, 1'b0,
                     INSTR_TYPE_S, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd28, 5'd2};
        vecs[5]  = '{32'h0000001B, 64'h114, INSTR_TYPE_R, 1'b1,
                     INSTR_TYPE_I, 1'b0, 64'h0, 5'd0, 5'd0};
        vecs[6]  = '{32'h00000000, 64'h118, INSTR_TYPE_R, 1'b1,
                     INSTR_TYPE_R, 1'b1, 64'h0, 5'd0, 5'd0};
        vecs[7]  = '{32'h00B50533, 64'h11C, INSTR_TYPE_R, 1'b0,
                     INSTR_TYPE_R, 1'b0, 64'h0, 5'd10, 5'd10};
        vecs[8]  = '{32'h0000003B, 64'h120, INSTR_TYPE_R, 1'b1,
                     INSTR_TYPE_R, 1'b0, 64'h0, 5'd0, 5'd0};
        vecs[9]  = '{32'hFFF00091, 64'h124, INSTR_TYPE_R, 1'b1,
                     INSTR_TYPE_R, 1'b1, 64'h0, 5'd1, 5'd0};
        vecs[10] = '{32'h00412083, 64'h128, INSTR_TYPE_I, 1'b0,
                     INSTR_TYPE_I, 1'b0, 64'h4, 5'd1, 5'd2};
        vecs[11] = '{32'hFFFFF017, 64'h12C, INSTR_TYPE_U, 1'b0,
                     INSTR_TYPE_U, 1'b0, 64'hFFFF_FFFF_FFFF_F000, 5'd0, 5'd31};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ready64 = 1'b1; in_instr = '0; pc64 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_imm", 64'(imm), 64'd0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Decode table, one beat at a time, both widths
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            pc64     = vecs[i].pc;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_type32", i), 64'(instr_type),
                  64'(vecs[i].t32));
            check($sformatf("v%0d_ill32", i), 64'(illegal),
                  64'(vecs[i].ill32));
            check($sformatf("v%0d_imm32", i), 64'(imm),
                  vecs[i].ill32 ? 64'd0 : 64'(vecs[i].imm[31:0]));
            check($sformatf("v%0d_rd", i), 64'(rd), 64'(vecs[i].rd));
            check($sformatf("v%0d_rs1", i), 64'(rs1), 64'(vecs[i].rs1));
            check($sformatf("v%0d_pc32", i), 64'(out_pc),
                  64'(vecs[i].pc[31:0]));
            check($sformatf("v%0d_type64", i), 64'(instr_type64),
                  64'(vecs[i].t64));
            check($sformatf("v%0d_ill64", i), 64'(illegal64),
                  64'(vecs[i].ill64));
            check($sformatf("v%0d_imm64", i), imm64,
                  vecs[i].ill64 ? 64'd0 : vecs[i].imm);
        end
        @(negedge clk);
        check("tbl_drained", 64'(out_valid), 64'd0);

        // Backpressure: three beats into a two-entry queue
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        pc64      = 64'h200;
        @(negedge clk);
        pc64 = 64'h204;
        @(negedge clk);
        check("bp_count_full", 64'(count), 64'd2);
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        pc64 = 64'h208;
        @(negedge clk);
        check("bp_stall_count", 64'(count), 64'd2);
        check("bp_stall_head", 64'(out_pc), 64'h200);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_head1", 64'(out_pc), 64'h204);
        check("bp_count1", 64'(count), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_head2", 64'(out_pc), 64'h208);
        check("bp_count2", 64'(count), 64'd1);
        @(negedge clk);
        check("bp_empty_valid", 64'(out_valid), 64'd0);
        check("bp_empty_pc", 64'(out_pc), 64'd0);
        check("bp_empty_rd", 64'(rd), 64'd0);

        // Streaming with one entry resident
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pc64      = 64'h300;
        @(negedge clk);
        check("st_head0", 64'(out_pc), 64'h300);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc64 = 64'h304 + 64'(4 * i);
            @(negedge clk);
            check($sformatf("st%0d_count", i), 64'(count), 64'd1);
            check($sformatf("st%0d_head", i), 64'(out_pc),
                  64'h304 + 64'(4 * i));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("st_drained", 64'(count), 64'd0);

        // Flush from full, with an input beat offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pc64      = 64'h400;
        @(negedge clk);
        pc64 = 64'h404;
        @(negedge clk);
        check("fl_full", 64'(count), 64'd2);
        flush = 1'b1;
        pc64  = 64'h408;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_count", 64'(count), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);

        // Flush with room: concurrent push and pop both ignored
        in_valid = 1'b1;
        pc64     = 64'h500;
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        pc64      = 64'h504;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fl2_count", 64'(count), 64'd0);
        check("fl2_valid64", 64'(out_valid64), 64'd0);

        // Reset mid-stream
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        pc64     = 64'h600;
        @(negedge clk);
        pc64 = 64'h604;
        @(negedge clk);
        check("rs_full", 64'(count), 64'd2);
        rst  = 1'b1;
        pc64 = 64'h608;
        #1 check("rs_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rs_count", 64'(count), 64'd0);
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_pc", 64'(out_pc), 64'd0);
        check("rs_imm", 64'(imm), 64'd0);
        check("rs_type", 64'(instr_type), 64'(INSTR_TYPE_R));
        check("rs_illegal", 64'(illegal), 64'd0);
        check("rs_in_ready_hold", 64'(in_ready), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1 check("rs_in_ready_after", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("rs_still_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath/immediate width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 2, meaning decoded-entry queue depth; power of two, >=2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  discard all queued entries and the current input beat.
REQ-006 in_valid  input  1  in_instr/in_pc valid.
REQ-007 in_ready  output  1  stage accepts a beat this cycle.
REQ-008 in_instr  input  32  raw instruction word.
REQ-009 in_pc  input  XLEN  instruction address.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer takes head entry.
REQ-012 out_pc  output  XLEN  PC of head entry.
REQ-013 rd, rs1, rs2  output  5 each  Instr[11:7], [19:15], [24:20] of head entry.
REQ-014 funct3  output  3  Instr[14:12]; funct7  output  7  Instr[31:25].
REQ-015 imm  output  XLEN  sign-extended immediate of head entry.
REQ-016 instr_type  output  instr_type_enum  INSTR_TYPE_R/I/S/B/U/J of head entry.
REQ-017 illegal  output  1  head entry has unsupported encoding.
REQ-018 count  output  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-019 Type SHALL be derived internally from opcode Instr[6:0]: 0110011 R; 0010011/0000011/1100111/1110011/0001111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J.
REQ-020 When XLEN=64, 0011011 SHALL decode as I and 0111011 as R; when XLEN=32 both SHALL be illegal.
REQ-021 Instr[1:0]!=2'b11 or any opcode not listed SHALL set illegal=1, instr_type=INSTR_TYPE_R, imm=0; register/funct fields still passed raw.
REQ-022 Immediates SHALL sign-extend Instr[31] to XLEN: I {Instr[31:20]}; S {Instr[31:25],Instr[11:7]}; B {Instr[7],Instr[30:25],Instr[11:8],0}; J {Instr[19:12],Instr[20],Instr[30:21],0}; U {Instr[31:12],12'b0}; R zero.
REQ-023 Decode SHALL be combinational on the input beat; decoded result is written into the queue on accept (in_valid & in_ready).
REQ-024 Latency: an entry accepted at edge N SHALL appear at outputs with out_valid=1 after edge N (one cycle); no combinational in-to-out path.
REQ-025 in_ready SHALL equal (count<DEPTH) & !rst; no push when full, even if out_ready=1 that cycle.
REQ-026 Pop occurs on out_valid & out_ready; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-027 out_valid SHALL equal (count!=0); output fields always reflect queue head; when empty, output fields SHALL hold zero and illegal=0.
REQ-028 Queue SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-029 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 flush=1 SHALL set count=0 at next edge, drop any concurrent push, and ignore concurrent pop; flush has priority over push/pop.
REQ-031 in_valid with in_ready=0 SHALL not change state; upstream holds beat.

Reset
REQ-032 rst=1 SHALL at next edge set count=0, pointers=0, out_valid=0, all output fields 0, illegal=0, instr_type=INSTR_TYPE_R.
REQ-033 in_ready SHALL be 0 while rst=1; rst has priority over flush, push and pop; reset mid-stream discards all entries.

Verification
REQ-034 Single I beat: in_instr=32'hFFF00093 (addi x1,x0,-1), in_pc=0x100 -> next cycle out_valid=1, INSTR_TYPE_I, rd=1, rs1=0, imm=all-ones (XLEN), out_pc=0x100.
REQ-035 Immediates: B 32'hFE000EE3 -> imm=-4; J 32'h0080006F -> imm=8; U 32'h123450B7 -> imm=0x12345000; S 32'hFE112E23 -> imm=-4.
REQ-036 Backpressure, DEPTH=2: out_ready=0, push 3 beats -> third stalled (in_ready=0, count=2); release out_ready -> beats exit in order, third then accepted.
REQ-037 Full plus same-cycle push/pop: count=1, in_valid=out_ready=1 for 10 cycles -> count stays 1, all 10 beats in order.
REQ-038 Illegal/XLEN: in_instr=32'h0000001B -> XLEN=32 illegal=1 imm=0; XLEN=64 INSTR_TYPE_I illegal=0; in_instr=32'h00000000 -> illegal=1.
REQ-039 Flush and reset: count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, beat dropped; repeat with rst=1 -> all outputs zero, in_ready=0 during rst, 1 after.
